multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 76 +++++++
 rtl/multicycle_control_if.sv | 54 +++++
 rtl/multicycle_control_alu_decoder.sv | 50 +++++
 rtl/multicycle_control.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle MIPS-subset controller:
//   - state_e      : FSM state encoding (also exported on the debug port)
//   - OP_* / FN_*  : instruction opcode and R-type funct field values
//   - ALU_*        : 4-bit ALU control codes (zero-extended by users)
//   - aluop_e      : request from the FSM to the ALU decoder
//   - alusrcb_e    : ALU B operand mux select
//   - pcsource_e   : PC source mux select
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_ILLEGAL = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALUOP_NONE yields an all-zero control word so idle states never
    // leave a stale operation on the ALU control lines.
    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_SUB   = 2'b10,
        ALUOP_FUNCT = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsource_e;

    // States in which the controller owns a memory access and waits on
    // mem_ready.
    function automatic logic isMemWaitState(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multicycle controller and its datapath/memory.
//   Inputs to controller : opcode, funct, zero, mem_ready
//   Outputs of controller: mem_req, MemRead, MemWrite, IorD, IRWrite,
//                          PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB,
//                          alu_ctrl, RegDst, RegWrite, MemToReg,
//                          illegal_op, mem_err, state
// Modports:
//   master : the controller
//   slave  : the datapath / memory side
// ----------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int ALU_CTRL_W = 4
);

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  mem_ready;

    logic                  mem_req;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  IorD;
    logic                  IRWrite;
    logic                  PCWrite;
    logic                  PCWriteCond;
    logic [1:0]            PCSource;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  RegDst;
    logic                  RegWrite;
    logic                  MemToReg;
    logic                  illegal_op;
    logic                  mem_err;
    logic [3:0]            state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite,
               PCWriteCond, PCSource, ALUSrcA, ALUSrcB, alu_ctrl,
               RegDst, RegWrite, MemToReg, illegal_op, mem_err, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite,
               PCWriteCond, PCSource, ALUSrcA, ALUSrcB, alu_ctrl,
               RegDst, RegWrite, MemToReg, illegal_op, mem_err, state
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode.
//   aluOp_i        : operation requested by the FSM (none/add/sub/funct)
//   funct_i        : IR[5:0], used only when aluOp_i == ALUOP_FUNCT
//   aluCtrl_o      : ALU control code, zero-extended to ALU_CTRL_W
//   illegalFunct_o : funct not supported (only meaningful for ALUOP_FUNCT)
// ----------------------------------------------------------------------------
module alu_decoder
    import multicycle_control_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  aluop_e                aluOp_i,
    input  logic [5:0]            funct_i,
    output logic [ALU_CTRL_W-1:0] aluCtrl_o,
    output logic                  illegalFunct_o
);

    logic [3:0] code;

    // Map the FSM request to a 4-bit code; an unknown funct gives code 0
    // and raises the illegal flag so the FSM can divert to ILLEGAL.
    always_comb begin
        code           = 4'b0000;
        illegalFunct_o = 1'b0;
        case (aluOp_i)
            ALUOP_NONE: code = 4'b0000;
            ALUOP_ADD:  code = ALU_ADD;
            ALUOP_SUB:  code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    default: begin
                        code           = 4'b0000;
                        illegalFunct_o = 1'b1;
                    end
                endcase
            end
            default: code = 4'b0000;
        endcase
    end

    assign aluCtrl_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle MIPS subset (lw, sw, R-type
// add/sub/and/or/slt, beq, addi, j) with a memory handshake and a
// memory wait timeout.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : multicycle_control_if.master (instruction fields, ALU zero,
//           mem_ready in; all datapath/memory control strobes and the
//           debug state out)
// Parameters:
//   ALU_CTRL_W  : ALU control width (>= 4)
//   MEM_TIMEOUT : max cycles to wait for mem_ready, 0 = wait forever
// ----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      waitCount_q, waitCount_d;
    logic                  dropStrobes_q, dropStrobes_d;

    logic                  inMemWait;
    logic                  memTimeout;
    aluop_e                aluOp;
    logic [ALU_CTRL_W-1:0] aluCtrl;
    logic                  illegalFunct;

    logic                  memReq;
    logic                  memRead;
    logic                  memWrite;
    logic                  iorD;
    logic                  irWrite;
    logic                  pcWrite;
    logic                  pcWriteCond;
    pcsource_e             pcSource;
    logic                  aluSrcA;
    alusrcb_e              aluSrcB;
    logic                  regDst;
    logic                  regWrite;
    logic                  memToReg;
    logic                  illegalOp;

    // The ALU zero flag is combined with PCWriteCond by the datapath; the
    // controller only passes the bundle through.
    logic                  unusedZero;
    assign unusedZero = bus.zero;

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .aluOp_i        (aluOp),
        .funct_i        (bus.funct),
        .aluCtrl_o      (aluCtrl),
        .illegalFunct_o (illegalFunct)
    );

    // A timeout is only possible while an access is actually outstanding;
    // the one-cycle strobe-drop after an abort does not count as waiting.
    assign inMemWait  = isMemWaitState(state_q) && !dropStrobes_q;
    assign memTimeout = (MEM_TIMEOUT != 0) && inMemWait && !bus.mem_ready &&
                        (waitCount_q == CNT_LAST);

    // State, wait counter and abort flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            waitCount_q   <= '0;
            dropStrobes_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            waitCount_q   <= waitCount_d;
            dropStrobes_q <= dropStrobes_d;
        end
    end

    // Next-state logic. A timeout aborts to FETCH with all memory strobes
    // held low for one cycle so the memory sees the request withdrawn
    // before the fetch is reissued.
    always_comb begin
        state_d       = state_q;
        dropStrobes_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (dropStrobes_q) begin
                    state_d = ST_FETCH;
                end else if (memTimeout) begin
                    state_d       = ST_FETCH;
                    dropStrobes_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = ST_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = ST_MEMWR;
                end else begin
                    state_d = ST_ILLEGAL;
                end
            end
            ST_MEMRD: begin
                if (memTimeout) begin
                    state_d       = ST_FETCH;
                    dropStrobes_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = ST_MEMWB;
                end
            end
            ST_MEMWR: begin
                if (memTimeout) begin
                    state_d       = ST_FETCH;
                    dropStrobes_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC:    state_d = illegalFunct ? ST_ILLEGAL : ST_ALUWB;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            ST_MEMWB,
            ST_ALUWB,
            ST_BRANCH,
            ST_ADDIWB,
            ST_JUMP,
            ST_ILLEGAL: state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Wait counter: counts consecutive not-ready cycles while staying in
    // the same access state; any state change, abort or completion
    // restarts it from zero, which covers (re)entry to a wait state.
    always_comb begin
        waitCount_d = '0;
        if (inMemWait && (state_d == state_q) && !dropStrobes_d &&
            !bus.mem_ready) begin
            waitCount_d = waitCount_q + CNT_W'(1);
        end
    end

    // Output decode from the current state. FETCH additionally qualifies
    // IRWrite/PCWrite with mem_ready. While rst_n is low every strobe is
    // forced off and the mux selects sit at their FETCH values, so a reset
    // in the middle of an access cannot produce a stray write.
    always_comb begin
        memReq      = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSource    = PCSRC_ALU;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_B;
        aluOp       = ALUOP_NONE;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        memToReg    = 1'b0;
        illegalOp   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                aluSrcB = SRCB_FOUR;
                aluOp   = ALUOP_ADD;
                if (!dropStrobes_q) begin
                    memReq  = 1'b1;
                    memRead = 1'b1;
                    irWrite = bus.mem_ready;
                    pcWrite = bus.mem_ready;
                end
            end
            ST_DECODE: begin
                aluSrcB = SRCB_IMM_SH;
                aluOp   = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                memReq  = 1'b1;
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            ST_MEMWR: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            ST_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            ST_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_B;
                aluOp   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            ST_BRANCH: begin
                aluSrcA     = 1'b1;
                aluSrcB     = SRCB_B;
                aluOp       = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
            end
            ST_ADDIWB: begin
                regWrite = 1'b1;
            end
            ST_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
            end
            ST_ILLEGAL: begin
                illegalOp = 1'b1;
            end
            default: begin
            end
        endcase

        if (!rst_n) begin
            memReq      = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            iorD        = 1'b0;
            irWrite     = 1'b0;
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            pcSource    = PCSRC_ALU;
            aluSrcA     = 1'b0;
            aluSrcB     = SRCB_FOUR;
            aluOp       = ALUOP_ADD;
            regDst      = 1'b0;
            regWrite    = 1'b0;
            memToReg    = 1'b0;
            illegalOp   = 1'b0;
        end
    end

    assign bus.mem_req     = memReq;
    assign bus.MemRead     = memRead;
    assign bus.MemWrite    = memWrite;
    assign bus.IorD        = iorD;
    assign bus.IRWrite     = irWrite;
    assign bus.PCWrite     = pcWrite;
    assign bus.PCWriteCond = pcWriteCond;
    assign bus.PCSource    = pcSource;
    assign bus.ALUSrcA     = aluSrcA;
    assign bus.ALUSrcB     = aluSrcB;
    assign bus.alu_ctrl    = aluCtrl;
    assign bus.RegDst      = regDst;
    assign bus.RegWrite    = regWrite;
    assign bus.MemToReg    = memToReg;
    assign bus.illegal_op  = illegalOp;
    assign bus.mem_err     = memTimeout && rst_n;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Directed, table-driven bench for multicycle_control (MEM_TIMEOUT = 4).
// Each row drives one cycle of inputs and holds the hand-derived state and
// control word expected in that cycle; short hand-written sequences cover
// memory waits, timeouts, reset during an access and illegal funct.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int ALU_W   = 4;
    localparam int TIMEOUT = 4;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_BAD = 6'b000111;
    localparam logic [5:0] F_NA  = 6'b000000;

    typedef struct packed {
        logic       memReq;
        logic       memRead;
        logic       memWrite;
        logic       iorD;
        logic       irWrite;
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluCtrl;
        logic       regDst;
        logic       regWrite;
        logic       memToReg;
        logic       illegalOp;
        logic       memErr;
    } ctrl_t;

    typedef struct {
        logic       rstN;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       zero;
        logic       memReady;
        logic [3:0] expState;
        ctrl_t      expCtrl;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    multicycle_control_if #(.ALU_CTRL_W(ALU_W)) bus ();

    multicycle_control #(
        .ALU_CTRL_W  (ALU_W),
        .MEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected control words, one per state, written from the state table.
    function automatic ctrl_t cIdle();
        ctrl_t c = '0;
        c.aluSrcB = 2'b01;
        c.aluCtrl = 4'b0010;
        return c;
    endfunction

    function automatic ctrl_t cFetch(input logic ready, input logic err);
        ctrl_t c = cIdle();
        c.memReq  = 1'b1;
        c.memRead = 1'b1;
        c.irWrite = ready;
        c.pcWrite = ready;
        c.memErr  = err;
        return c;
    endfunction

    function automatic ctrl_t cDecode();
        ctrl_t c = '0;
        c.aluSrcB = 2'b11;
        c.aluCtrl = 4'b0010;
        return c;
    endfunction

    function automatic ctrl_t cAddrImm();
        ctrl_t c = '0;
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
        c.aluCtrl = 4'b0010;
        return c;
    endfunction

    function automatic ctrl_t cMemRd(input logic err);
        ctrl_t c = '0;
        c.memReq  = 1'b1;
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
        c.memErr  = err;
        return c;
    endfunction

    function automatic ctrl_t cMemWr();
        ctrl_t c = '0;
        c.memReq   = 1'b1;
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cMemWb();
        ctrl_t c = '0;
        c.regWrite = 1'b1;
        c.memToReg = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cExec(input logic [3:0] alu);
        ctrl_t c = '0;
        c.aluSrcA = 1'b1;
        c.aluCtrl = alu;
        return c;
    endfunction

    function automatic ctrl_t cAluWb();
        ctrl_t c = '0;
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cBranch();
        ctrl_t c = '0;
        c.aluSrcA     = 1'b1;
        c.aluCtrl     = 4'b0110;
        c.pcWriteCond = 1'b1;
        c.pcSource    = 2'b01;
        return c;
    endfunction

    function automatic ctrl_t cAddiWb();
        ctrl_t c = '0;
        c.regWrite = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cJump();
        ctrl_t c = '0;
        c.pcWrite  = 1'b1;
        c.pcSource = 2'b10;
        return c;
    endfunction

    function automatic ctrl_t cIllegal();
        ctrl_t c = '0;
        c.illegalOp = 1'b1;
        return c;
    endfunction

    function automatic vec_t mkVec(input logic rstN, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z,
                                   input logic rdy, input logic [3:0] st,
                                   input ctrl_t c);
        vec_t v;
        v.rstN     = rstN;
        v.opcode   = op;
        v.funct    = fn;
        v.zero     = z;
        v.memReady = rdy;
        v.expState = st;
        v.expCtrl  = c;
        return v;
    endfunction

    function automatic ctrl_t readActual();
        ctrl_t c;
        c.memReq      = bus.mem_req;
        c.memRead     = bus.MemRead;
        c.memWrite    = bus.MemWrite;
        c.iorD        = bus.IorD;
        c.irWrite     = bus.IRWrite;
        c.pcWrite     = bus.PCWrite;
        c.pcWriteCond = bus.PCWriteCond;
        c.pcSource    = bus.PCSource;
        c.aluSrcA     = bus.ALUSrcA;
        c.aluSrcB     = bus.ALUSrcB;
        c.aluCtrl     = bus.alu_ctrl;
        c.regDst      = bus.RegDst;
        c.regWrite    = bus.RegWrite;
        c.memToReg    = bus.MemToReg;
        c.illegalOp   = bus.illegal_op;
        c.memErr      = bus.mem_err;
        return c;
    endfunction

    task automatic applyStimulus(input logic rstN, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z,
                                 input logic rdy);
        rst_n         = rstN;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input int idx,
                               input logic [3:0] expState,
                               input ctrl_t expCtrl);
        ctrl_t act;
        act = readActual();
        checks++;
        if (bus.state !== expState) begin
            errors++;
            $display("[TB] FAIL %s[%0d] state: got %0d expected %0d",
                     tag, idx, bus.state, expState);
        end
        checks++;
        if (act !== expCtrl) begin
            errors++;
            $display("[TB] FAIL %s[%0d] ctrl: got %06h expected %06h (state %0d)",
                     tag, idx, act, expCtrl, bus.state);
        end
    endtask

    // One cycle: drive inputs after the edge, check mid-cycle, advance.
    task automatic step(input string tag, input int idx, input vec_t v);
        applyStimulus(v.rstN, v.opcode, v.funct, v.zero, v.memReady);
        #1;
        checkOutput(tag, idx, v.expState, v.expCtrl);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, F_NA, F_NA, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1'b0, F_NA, F_NA, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset held with mem_ready high: strobes must stay off.
        vecs.push_back(mkVec(0, LW, F_NA, 0, 1, 4'd0, cIdle()));
        // lw, immediate ready: 0,1,2,3,4
        vecs.push_back(mkVec(1, LW, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, LW, F_NA, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, LW, F_NA, 0, 1, 4'd2, cAddrImm()));
        vecs.push_back(mkVec(1, LW, F_NA, 0, 1, 4'd3, cMemRd(0)));
        vecs.push_back(mkVec(1, LW, F_NA, 0, 1, 4'd4, cMemWb()));
        // R-type add, slt, sub, and, or
        vecs.push_back(mkVec(1, RT, F_ADD, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, RT, F_ADD, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, RT, F_ADD, 0, 1, 4'd6, cExec(4'b0010)));
        vecs.push_back(mkVec(1, RT, F_ADD, 0, 1, 4'd7, cAluWb()));
        vecs.push_back(mkVec(1, RT, F_SLT, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, RT, F_SLT, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, RT, F_SLT, 0, 1, 4'd6, cExec(4'b0111)));
        vecs.push_back(mkVec(1, RT, F_SLT, 0, 1, 4'd7, cAluWb()));
        vecs.push_back(mkVec(1, RT, F_SUB, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, RT, F_SUB, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, RT, F_SUB, 0, 1, 4'd6, cExec(4'b0110)));
        vecs.push_back(mkVec(1, RT, F_SUB, 0, 1, 4'd7, cAluWb()));
        vecs.push_back(mkVec(1, RT, F_AND, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, RT, F_AND, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, RT, F_AND, 0, 1, 4'd6, cExec(4'b0000)));
        vecs.push_back(mkVec(1, RT, F_AND, 0, 1, 4'd7, cAluWb()));
        vecs.push_back(mkVec(1, RT, F_OR, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, RT, F_OR, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, RT, F_OR, 0, 1, 4'd6, cExec(4'b0001)));
        vecs.push_back(mkVec(1, RT, F_OR, 0, 1, 4'd7, cAluWb()));
        // beq with zero=1
        vecs.push_back(mkVec(1, BEQ, F_NA, 1, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, BEQ, F_NA, 1, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, BEQ, F_NA, 1, 1, 4'd8, cBranch()));
        // addi
        vecs.push_back(mkVec(1, ADDI, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, ADDI, F_NA, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, ADDI, F_NA, 0, 1, 4'd9, cAddrImm()));
        vecs.push_back(mkVec(1, ADDI, F_NA, 0, 1, 4'd10, cAddiWb()));
        // j
        vecs.push_back(mkVec(1, JMP, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, JMP, F_NA, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, JMP, F_NA, 0, 1, 4'd11, cJump()));
        // unsupported opcode
        vecs.push_back(mkVec(1, BAD, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, BAD, F_NA, 0, 1, 4'd1, cDecode()));
        vecs.push_back(mkVec(1, BAD, F_NA, 0, 1, 4'd12, cIllegal()));
        // fetch waits one cycle, then completes
        vecs.push_back(mkVec(1, LW, F_NA, 0, 0, 4'd0, cFetch(0, 0)));
        vecs.push_back(mkVec(1, LW, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        vecs.push_back(mkVec(1, LW, F_NA, 0, 1, 4'd1, cDecode()));

        foreach (vecs[i]) step("table", i, vecs[i]);

        // sw with three not-ready cycles in MEMWR
        doReset();
        step("swWait", 0, mkVec(1, SW, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        step("swWait", 1, mkVec(1, SW, F_NA, 0, 1, 4'd1, cDecode()));
        step("swWait", 2, mkVec(1, SW, F_NA, 0, 1, 4'd2, cAddrImm()));
        for (int k = 0; k < 3; k++)
            step("swWait", 3 + k, mkVec(1, SW, F_NA, 0, 0, 4'd5, cMemWr()));
        step("swWait", 6, mkVec(1, SW, F_NA, 0, 1, 4'd5, cMemWr()));
        step("swWait", 7, mkVec(1, SW, F_NA, 0, 0, 4'd0, cFetch(0, 0)));

        // fetch timeout: error on the 4th wait cycle, then one dead cycle
        doReset();
        for (int k = 0; k < 3; k++)
            step("fetchTo", k, mkVec(1, LW, F_NA, 0, 0, 4'd0, cFetch(0, 0)));
        step("fetchTo", 3, mkVec(1, LW, F_NA, 0, 0, 4'd0, cFetch(0, 1)));
        step("fetchTo", 4, mkVec(1, LW, F_NA, 0, 1, 4'd0, cIdle()));
        step("fetchTo", 5, mkVec(1, LW, F_NA, 0, 0, 4'd0, cFetch(0, 0)));
        step("fetchTo", 6, mkVec(1, LW, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        step("fetchTo", 7, mkVec(1, LW, F_NA, 0, 1, 4'd1, cDecode()));

        // reset asserted while MEMWR is waiting
        doReset();
        step("rstMemWr", 0, mkVec(1, SW, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        step("rstMemWr", 1, mkVec(1, SW, F_NA, 0, 1, 4'd1, cDecode()));
        step("rstMemWr", 2, mkVec(1, SW, F_NA, 0, 1, 4'd2, cAddrImm()));
        step("rstMemWr", 3, mkVec(1, SW, F_NA, 0, 0, 4'd5, cMemWr()));
        step("rstMemWr", 4, mkVec(0, SW, F_NA, 0, 0, 4'd5, cIdle()));
        step("rstMemWr", 5, mkVec(1, SW, F_NA, 0, 0, 4'd0, cFetch(0, 0)));

        // R-type with unsupported funct
        doReset();
        step("badFunct", 0, mkVec(1, RT, F_BAD, 0, 1, 4'd0, cFetch(1, 0)));
        step("badFunct", 1, mkVec(1, RT, F_BAD, 0, 1, 4'd1, cDecode()));
        step("badFunct", 2, mkVec(1, RT, F_BAD, 0, 1, 4'd6, cExec(4'b0000)));
        step("badFunct", 3, mkVec(1, RT, F_BAD, 0, 1, 4'd12, cIllegal()));
        step("badFunct", 4, mkVec(1, RT, F_BAD, 0, 0, 4'd0, cFetch(0, 0)));

        // lw whose data read times out in MEMRD
        doReset();
        step("rdTo", 0, mkVec(1, LW, F_NA, 0, 1, 4'd0, cFetch(1, 0)));
        step("rdTo", 1, mkVec(1, LW, F_NA, 0, 1, 4'd1, cDecode()));
        step("rdTo", 2, mkVec(1, LW, F_NA, 0, 1, 4'd2, cAddrImm()));
        for (int k = 0; k < 3; k++)
            step("rdTo", 3 + k, mkVec(1, LW, F_NA, 0, 0, 4'd3, cMemRd(0)));
        step("rdTo", 6, mkVec(1, LW, F_NA, 0, 0, 4'd3, cMemRd(1)));
        step("rdTo", 7, mkVec(1, LW, F_NA, 0, 0, 4'd0, cIdle()));
        step("rdTo", 8, mkVec(1, LW, F_NA, 0, 0, 4'd0, cFetch(0, 0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
